shift_exec_stage: RTL
=====================

Name: shift_exec_stage

Overview:
- Execute-stage shift unit for the RV32 core.
- Sits between issue/operand-read and writeback arbitration.
- Decodes funct3/funct7 into direction/arith controls and drives one combinational barrel shifter.
- Registers the result with a one-cycle latency under a valid/ready handshake; a skid buffer gives full throughput with a registered o_ready.

Parameters:
- XLEN, 32, datapath width (fixed at 32; other values unsupported).
- TAG_W, 5, width of the destination tag (rd index) carried alongside the result.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_flush  input  1  discard all held ops (pipeline redirect).
- i_valid  input  1  upstream op valid.
- o_ready  output  1  stage can accept an op; registered, equals !skid_valid.
- i_funct3  input  3  instruction funct3.
- i_funct7  input  7  instruction funct7 (imm[11:5] for immediate forms).
- i_use_imm  input  1  1 = amount from i_shamt, 0 = amount from i_rs2[4:0].
- i_rs1  input  32  operand to shift.
- i_rs2  input  32  register shift amount source; only bits [4:0] are used.
- i_shamt  input  5  immediate shift amount.
- i_rd  input  TAG_W  destination tag.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_result  output  32  shifted value.
- o_rd  output  TAG_W  destination tag of o_result.
- o_we  output  1  register write enable: o_valid && o_rd != 0 && !o_illegal.
- o_illegal  output  1  op was not a legal shift encoding.

Behaviour:
- Decode:
  - SLL: funct3 001, funct7 0000000 (dir = 0).
  - SRL: funct3 101, funct7 0000000 (dir = 1, arith = 0).
  - SRA: funct3 101, funct7 0100000 (dir = 1, arith = 1).
  - Any other combination is illegal: o_illegal = 1, o_result = 0, tag passed through.
- Amount: i_use_imm ? i_shamt : i_rs2[4:0]. Upper bits of i_rs2 are ignored.
- Handshakes:
  - Accept when i_valid && o_ready.
  - Output transfer when o_valid && i_ready.
  - o_valid, o_result, o_rd and o_illegal stay stable while o_valid && !i_ready.
- Storage: output register (OUT) plus one skid register (SKID). States, encoded by {skid_valid, out_valid}:
  - EMPTY: accept -> ONE.
  - ONE:
    - accept && transfer -> ONE (OUT replaced).
    - accept && !transfer -> FULL (new op to SKID).
    - transfer only -> EMPTY.
  - FULL: o_ready = 0. Transfer -> ONE (SKID moves to OUT).
- Timing and ordering:
  - Latency is 1 cycle from accept to o_valid when the stage was EMPTY, or when it was ONE with a same-cycle transfer.
  - Sustained throughput is 1 op/cycle.
  - Ops leave in acceptance order.
- Flush:
  - i_flush clears out_valid and skid_valid next cycle.
  - An op presented on the same cycle is dropped; o_ready reads 1 the next cycle.
  - Flush takes priority over accept and transfer. A transfer in the flush cycle still counts as completed downstream.
- Reset: o_valid = 0, o_ready = 1, o_result = 0, o_rd = 0, o_illegal = 0, o_we = 0, skid_valid = 0. Reset mid-operation discards everything, same as flush.
- Boundary cases:
  - Amount 0 returns i_rs1 unchanged.
  - SRA by 31 yields all bits equal to rs1[31].
  - rd = 0 still produces a valid result with o_we = 0.
- Result is computed combinationally at accept time. The data registers hold only final values, so operands may change after acceptance.

Optional Feature:
- Macro SHIFT_ROTATE_EN.
- Defined:
  - Adds ROL (funct3 001, funct7 0110000, register form only) and ROR/RORI (funct3 101, funct7 0110000).
  - Rotate result = (rs1 << amt) | (rs1 >> ((32 - amt) mod 32)) for left, mirror for right; amount 0 returns rs1.
  - Uses a second barrel shifter instance.
  - ROL with i_use_imm = 1 stays illegal.
- Undefined:
  - Those encodings are illegal.
  - No second shifter is instantiated.

Test Plan:
- SRA, rs1 = 0x80000010, rs2 = 0x00000024 (amount 4) -> one cycle later o_valid = 1, o_result = 0xF8000001, o_we = 1 for rd = 7.
- Back-to-back SLL/SRL with i_ready = 1 constant, 8 ops -> 8 consecutive o_valid cycles, o_ready never drops, results in order.
- i_ready = 0 while 3 ops are offered -> two accepted (OUT + SKID), o_ready = 0 on the third, OUT stable. Raise i_ready -> results drain in order, o_ready returns to 1.
- Flush while FULL, with a new op presented -> next cycle o_valid = 0, o_ready = 1; none of the three ops ever appear.
- funct3 = 001, funct7 = 0100000 (no macro) -> o_illegal = 1, o_result = 0, o_we = 0. rd = 0 legal SLL -> o_valid = 1, o_we = 0.
- With SHIFT_ROTATE_EN: RORI, rs1 = 0x00000001, shamt = 1 -> 0x80000000. ROL, rs1 = 0x80000001, rs2 = 0 -> 0x80000001.

Source files
------------

// File: rtl/shift_exec_stage_if.sv
// Bundles the issue-side op, flush and writeback-side result signals of shift_exec_stage.
// dbg_state mirrors the storage state {skid_valid, out_valid} for observation.
interface shift_exec_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_funct3;
    logic [6:0]       i_funct7;
    logic             i_use_imm;
    logic [XLEN-1:0]  i_rs1;
    logic [XLEN-1:0]  i_rs2;
    logic [4:0]       i_shamt;
    logic [TAG_W-1:0] i_rd;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_result;
    logic [TAG_W-1:0] o_rd;
    logic             o_we;
    logic             o_illegal;
    logic [1:0]       dbg_state;

    // Handshake: an op moves on a rising edge where valid && ready; the sender
    // holds payload steady while valid && !ready, and valid never depends on ready.
    modport slave (
        input  i_flush, i_valid, i_funct3, i_funct7, i_use_imm, i_rs1, i_rs2,
               i_shamt, i_rd, i_ready,
        output o_ready, o_valid, o_result, o_rd, o_we, o_illegal, dbg_state
    );

    modport master (
        output i_flush, i_valid, i_funct3, i_funct7, i_use_imm, i_rs1, i_rs2,
               i_shamt, i_rd, i_ready,
        input  o_ready, o_valid, o_result, o_rd, o_we, o_illegal, dbg_state
    );
endinterface

// File: rtl/shift_exec_stage.sv
// RV32 execute-stage shift unit: decode, barrel shift, output register plus skid buffer.
// Optional rotates (ROL/ROR/RORI) are enabled by defining SHIFT_ROTATE_EN.
module shift_exec_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic           i_clk,
    input logic           i_rst,
    shift_exec_stage_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  out_result_q, out_result_d, skid_result_q, skid_result_d;
    logic [TAG_W-1:0] out_rd_q, out_rd_d, skid_rd_q, skid_rd_d;
    logic             out_illegal_q, out_illegal_d, skid_illegal_q, skid_illegal_d;

    logic [4:0]       amt;
    logic             is_sll, is_srl, is_sra, legal;
    logic [XLEN-1:0]  shr_in, shr_out, shift_res, new_result;
    logic             accept, transfer;
    logic             unused_rs2_hi;

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = d[XLEN-1-i];
        return r;
    endfunction

    // Logarithmic right shifter; left shifts reuse it through bit reversal.
    function automatic logic [XLEN-1:0] shift_right(input logic [XLEN-1:0] d,
                                                     input logic [4:0] a,
                                                     input logic fill);
        logic [XLEN-1:0] r;
        r = d;
        for (int s = 0; s < 5; s++)
            if (a[s]) r = (r >> (1 << s)) | (fill ? ~({XLEN{1'b1}} >> (1 << s)) : '0);
        return r;
    endfunction

    assign unused_rs2_hi = ^bus.i_rs2[XLEN-1:5];

`ifdef SHIFT_ROTATE_EN
    logic            is_rol, is_ror;
    logic [4:0]      rot_amt;
    logic [XLEN-1:0] rot_out;

    function automatic logic [XLEN-1:0] rotate_right(input logic [XLEN-1:0] d,
                                                     input logic [4:0] a);
        logic [XLEN-1:0] r;
        r = d;
        for (int s = 0; s < 5; s++)
            if (a[s]) r = (r >> (1 << s)) | (r << (XLEN - (1 << s)));
        return r;
    endfunction
`endif

    always_comb begin
        amt    = bus.i_use_imm ? bus.i_shamt : bus.i_rs2[4:0];
        is_sll = (bus.i_funct3 == 3'b001) && (bus.i_funct7 == 7'b0000000);
        is_srl = (bus.i_funct3 == 3'b101) && (bus.i_funct7 == 7'b0000000);
        is_sra = (bus.i_funct3 == 3'b101) && (bus.i_funct7 == 7'b0100000);
        shr_in    = is_sll ? bit_rev(bus.i_rs1) : bus.i_rs1;
        shr_out   = shift_right(shr_in, amt, is_sra & bus.i_rs1[XLEN-1]);
        shift_res = is_sll ? bit_rev(shr_out) : shr_out;
`ifdef SHIFT_ROTATE_EN
        is_rol  = (bus.i_funct3 == 3'b001) && (bus.i_funct7 == 7'b0110000) && !bus.i_use_imm;
        is_ror  = (bus.i_funct3 == 3'b101) && (bus.i_funct7 == 7'b0110000);
        // Rotate left by n equals rotate right by (32 - n) mod 32.
        rot_amt = is_rol ? (5'd0 - amt) : amt;
        rot_out = rotate_right(bus.i_rs1, rot_amt);
        legal   = is_sll | is_srl | is_sra | is_rol | is_ror;
        new_result = !legal ? '0 : ((is_rol | is_ror) ? rot_out : shift_res);
`else
        legal      = is_sll | is_srl | is_sra;
        new_result = legal ? shift_res : '0;
`endif
    end

    always_comb begin
        state_d        = state_q;
        out_result_d   = out_result_q;
        out_rd_d       = out_rd_q;
        out_illegal_d  = out_illegal_q;
        skid_result_d  = skid_result_q;
        skid_rd_d      = skid_rd_q;
        skid_illegal_d = skid_illegal_q;
        accept   = bus.i_valid && (state_q != FULL);
        transfer = (state_q != EMPTY) && bus.i_ready;
        if (bus.i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d       = ONE;
                    out_result_d  = new_result;
                    out_rd_d      = bus.i_rd;
                    out_illegal_d = !legal;
                end
                ONE: if (accept && transfer) begin
                    out_result_d  = new_result;
                    out_rd_d      = bus.i_rd;
                    out_illegal_d = !legal;
                end else if (accept) begin
                    state_d        = FULL;
                    skid_result_d  = new_result;
                    skid_rd_d      = bus.i_rd;
                    skid_illegal_d = !legal;
                end else if (transfer) begin
                    state_d = EMPTY;
                end
                FULL: if (transfer) begin
                    state_d       = ONE;
                    out_result_d  = skid_result_q;
                    out_rd_d      = skid_rd_q;
                    out_illegal_d = skid_illegal_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= EMPTY;
            out_result_q   <= '0;
            out_rd_q       <= '0;
            out_illegal_q  <= 1'b0;
            skid_result_q  <= '0;
            skid_rd_q      <= '0;
            skid_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_result_q   <= out_result_d;
            out_rd_q       <= out_rd_d;
            out_illegal_q  <= out_illegal_d;
            skid_result_q  <= skid_result_d;
            skid_rd_q      <= skid_rd_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

    assign bus.o_ready   = !state_q[1];
    assign bus.o_valid   = state_q[0];
    assign bus.o_result  = out_result_q;
    assign bus.o_rd      = out_rd_q;
    assign bus.o_illegal = out_illegal_q;
    assign bus.o_we      = state_q[0] && (out_rd_q != '0) && !out_illegal_q;
    assign bus.dbg_state = state_q;
endmodule
